uart_rx_multimode: RTL and testbench
====================================

Name: uart_rx_multimode

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Adds the following:
- configurable data width and oversampling ratio
- runtime parity (none/even/odd) and 1 or 2 stop bits
- input synchroniser and 3-sample majority vote
- false-start rejection
- parity/framing error flags

Sits between the rx pin and the command decoder. Driven by the shared baud-tick generator (sample_tick = OVERSAMPLE x baud).

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
OVERSAMPLE, 16, sample_tick pulses per bit period, even, >= 8
SYNC_STAGES, 2, flip-flops in rx synchroniser, >= 2

Ports:
clk_50MHz  input  1  system clock
reset  input  1  synchronous active-high reset
rx  input  1  asynchronous serial line, idle high
sample_tick  input  1  one-cycle oversampling strobe
parity_en  input  1  1 = parity bit present
parity_odd  input  1  1 = odd parity, 0 = even (ignored if parity_en=0)
two_stop  input  1  1 = two stop bits
data_valid  output  1  one-cycle pulse, frame complete
data_out  output  DATA_BITS  last received word, LSB = first bit on line
parity_err  output  1  parity mismatch in last frame
frame_err  output  1  a stop bit sampled low in last frame

Behaviour:
- Reset: synchronous, single cycle, at any time including mid-frame.
  - State goes to IDLE; counters cleared.
  - Synchroniser flops are set to 1.
  - data_valid, data_out, parity_err, frame_err are all 0.
- rx is used only after SYNC_STAGES flops (rx_s). Latency from pin to FSM is SYNC_STAGES cycles.
- Tick counter: 0..OVERSAMPLE-1; advances only on sample_tick; wraps to 0 at end of each bit.
- Majority vote: rx_s sampled on ticks M-1, M, M+1 (M = OVERSAMPLE/2). Bit value = majority of the 3 samples, resolved on tick M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s = 0, go to START. Clear tick counter. Latch parity_en, parity_odd, two_stop into internal mode registers; port changes mid-frame have no effect.
  - START: at vote tick, if vote = 1 (glitch), go to IDLE with no outputs changed. Else continue to tick OVERSAMPLE-1, then go to DATA with bit count 0.
  - DATA: at each vote, shift right (vote into MSB of DATA_BITS shift register); running XOR updated. After bit DATA_BITS-1 completes, go to PARITY if parity_en latched, else STOP.
  - PARITY: at vote, perr = (XOR of data bits ^ vote) != parity_odd. At bit end, go to STOP.
  - STOP: at vote of first stop bit, ferr |= ~vote. If two_stop, finish first bit and sample the second the same way. At vote tick of the final stop bit, complete the frame, then go to IDLE immediately (half bit early, so the next start edge is caught).
- Frame completion, same cycle:
  - data_out <= shift register
  - parity_err <= perr (0 when parity disabled)
  - frame_err <= ferr
  - data_valid = 1 for exactly one clk_50MHz cycle
- data_out and the flags hold until the next frame completion. Error frames still update data_out and pulse data_valid.
- Bit counter width: $clog2(DATA_BITS). Tick counter width: $clog2(OVERSAMPLE).
- No sample_tick: FSM frozen except the IDLE start detect.
- Frame completion and a new falling edge in the same cycle: completion wins. Edge is seen next cycle in IDLE.

Optional Feature:
Macro UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output port break_det (1 bit, reset 0) and state BREAK.
  - Break condition: frame_err, all data bits 0, and parity bit (if present) 0.
  - On break: break_det pulses one cycle; data_valid is NOT pulsed; data_out and flags are unchanged.
  - FSM enters BREAK and waits for rx_s = 1, then goes to IDLE. No frames are started while the line stays low.
- Undefined: no port or state. Such a frame completes normally (data_out 0, frame_err 1, data_valid pulse). If the line is still low, IDLE starts a new frame.

Test Plan:
1. Config: OVERSAMPLE=16, sample_tick every 27 cycles, 8N1. Send 0xA5 -> one data_valid pulse; data_out=0xA5; parity_err=0; frame_err=0.
2. 8E1, send 0x37 with parity bit 1 -> no error. Then 0x37 with parity bit 0 -> data_valid, data_out=0x37, parity_err=1. parity_odd=1 with bit 1 -> parity_err=1.
3. 8O2 (two_stop=1), send 0x81 with parity 1, second stop bit driven 0 -> data_out=0x81, frame_err=1, parity_err=0. Next clean frame 0x42 -> both flags clear.
4. rx low for 3 ticks, then high -> no data_valid, outputs unchanged. Following frame 0x5A -> data_out=0x5A. Also a single-tick low spike at a data-bit centre -> bit still read correctly (majority).
5. Assert reset for 1 cycle during data bit 4 of 0xFF -> all outputs 0. Following frame 0xC3 -> data_out=0xC3, no errors. Toggle two_stop mid-frame -> frame timing unaffected.
6. rx held low for 2 frame times:
   - With UART_RX_BREAK_DET_EN: one break_det pulse, no data_valid, nothing further until rx high; then 0x11 is received.
   - Without: data_valid with data_out=0x00, frame_err=1.

Source files
------------

// File: rtl/uart_rx_multimode.sv
// Oversampled UART receiver: configurable width/oversampling, runtime parity and stop bits.
// Optional break detection is compiled in with UART_RX_BREAK_DET_EN.
module uart_rx_multimode #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 sample_tick,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 frame_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_BREAK_DET_EN
  localparam logic [2:0] BREAK  = 3'd5;
  logic                 par_bit;
`endif

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [2:0]             state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   stop_cnt;
  logic                   s0, s1;
  logic [DATA_BITS-1:0]   sh;
  logic                   xr, perr, ferr;
  logic                   par_en_l, par_odd_l, two_stop_l;

  assign rx_s = sync[SYNC_STAGES-1];

  logic vote, vote_now, tick_end, ferr_nxt;
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign vote_now = sample_tick && (tick_cnt == T_VOTE);
  assign tick_end = sample_tick && (tick_cnt == T_LAST);
  assign ferr_nxt = ferr | ~vote;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sync       <= '1;
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      sh         <= '0;
      xr         <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      two_stop_l <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit    <= 1'b0;
      break_det  <= 1'b0;
`endif
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], rx};
      data_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det  <= 1'b0;
`endif
      if (sample_tick && state != IDLE) begin
        tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == T_S0) s0 <= rx_s;
        if (tick_cnt == T_S1) s1 <= rx_s;
      end

      case (state)
        IDLE: if (!rx_s) begin
          // mode is frozen for the whole frame
          state      <= START;
          tick_cnt   <= '0;
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          xr         <= 1'b0;
          perr       <= 1'b0;
          ferr       <= 1'b0;
          par_en_l   <= parity_en;
          par_odd_l  <= parity_odd;
          two_stop_l <= two_stop;
`ifdef UART_RX_BREAK_DET_EN
          par_bit    <= 1'b0;
`endif
        end
        START: begin
          if (vote_now && vote) state <= IDLE;
          else if (tick_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (vote_now) begin
            sh <= {vote, sh[DATA_BITS-1:1]};
            xr <= xr ^ vote;
          end
          if (tick_end) begin
            if (bit_cnt == B_LAST) state <= par_en_l ? PARITY : STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (vote_now) begin
            perr <= (xr ^ vote) != par_odd_l;
`ifdef UART_RX_BREAK_DET_EN
            par_bit <= vote;
`endif
          end
          if (tick_end) state <= STOP;
        end
        STOP: begin
          if (vote_now) begin
            ferr <= ferr_nxt;
            // final stop bit completes at its centre so the next start edge is caught
            if (stop_cnt == two_stop_l) begin
`ifdef UART_RX_BREAK_DET_EN
              if (ferr_nxt && sh == '0 && !(par_en_l && par_bit)) begin
                break_det <= 1'b1;
                state     <= BREAK;
              end else begin
                data_out   <= sh;
                parity_err <= perr;
                frame_err  <= ferr_nxt;
                data_valid <= 1'b1;
                state      <= IDLE;
              end
`else
              data_out   <= sh;
              parity_err <= perr;
              frame_err  <= ferr_nxt;
              data_valid <= 1'b1;
              state      <= IDLE;
`endif
            end
          end else if (tick_end) stop_cnt <= 1'b1;
        end
`ifdef UART_RX_BREAK_DET_EN
        BREAK: if (rx_s) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_multimode.sv
// Directed bench for uart_rx_multimode: 16x oversampling, sample_tick every 27 clocks.
module tb_uart_rx_multimode;
  localparam int OS   = 16;
  localparam int TICK = 27;
  localparam int BITC = OS * TICK;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       sample_tick = 1'b0;
  logic       parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic       data_valid, parity_err, frame_err;
  logic [7:0] data_out;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_det;
  int         brk_cnt = 0;
`endif

  int tests = 0, fails = 0;
  logic [9:0] q[$];

  uart_rx_multimode #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx(rx), .sample_tick(sample_tick),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .data_valid(data_valid), .data_out(data_out), .parity_err(parity_err),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(break_det),
`endif
    .frame_err(frame_err));

  always #10 clk_50MHz = ~clk_50MHz;

  initial forever begin
    repeat (TICK - 1) @(negedge clk_50MHz);
    sample_tick = 1'b1;
    @(negedge clk_50MHz);
    sample_tick = 1'b0;
  end

  always @(negedge clk_50MHz) begin
    if (data_valid) q.push_back({frame_err, parity_err, data_out});
`ifdef UART_RX_BREAK_DET_EN
    if (break_det) brk_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  // spike: one tick-period low pulse around the bit centre
  task automatic send_bit(input logic v, input logic spike);
    rx = v;
    if (spike) begin
      wait_cyc(229); rx = 1'b0;
      wait_cyc(TICK); rx = v;
      wait_cyc(BITC - 229 - TICK);
    end else wait_cyc(BITC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic s1, input logic s2, input logic two, input int spike_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == spike_bit);
    if (pe) send_bit(pbit, 1'b0);
    send_bit(s1, 1'b0);
    if (two) send_bit(s2, 1'b0);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    wait_cyc(n * BITC);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    logic [9:0] it;
    chk({tag, "_vld"}, 32'(q.size() != 0), 32'd1);
    it = (q.size() != 0) ? q.pop_front() : 10'h3ff;
    chk({tag, "_data"}, 32'(it[7:0]), 32'(d));
    chk({tag, "_perr"}, 32'(it[8]), 32'(pe));
    chk({tag, "_ferr"}, 32'(it[9]), 32'(fe));
  endtask

  initial begin
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    chk("rst_vld", 32'(data_valid), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    idle_bits(1);

    // 8N1
    send_frame(8'hA5, 0, 0, 1, 1, 0, -1); idle_bits(1);
    expect_frame("t1", 8'hA5, 0, 0);
    chk("t1_once", q.size(), 0);
    chk("t1_port", 32'(data_out), 32'hA5);

    // 8E1 and 8O1 parity
    parity_en = 1'b1;
    send_frame(8'h37, 1, 1, 1, 1, 0, -1); idle_bits(1);
    expect_frame("t2a", 8'h37, 0, 0);
    send_frame(8'h37, 1, 0, 1, 1, 0, -1); idle_bits(1);
    expect_frame("t2b", 8'h37, 1, 0);
    parity_odd = 1'b1;
    send_frame(8'h37, 1, 1, 1, 1, 0, -1); idle_bits(1);
    expect_frame("t2c", 8'h37, 1, 0);

    // 8O2, second stop bit low, then a clean frame
    two_stop = 1'b1;
    send_frame(8'h81, 1, 1, 1, 0, 1, -1); idle_bits(1);
    expect_frame("t3a", 8'h81, 0, 1);
    send_frame(8'h42, 1, 1, 1, 1, 1, -1); idle_bits(1);
    expect_frame("t3b", 8'h42, 0, 0);

    // false start, then a frame with a mid-bit spike
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    rx = 1'b0; wait_cyc(3 * TICK); idle_bits(2);
    chk("t4_glitch_cnt", q.size(), 0);
    chk("t4_glitch_data", 32'(data_out), 32'h42);
    send_frame(8'h5A, 0, 0, 1, 1, 0, 3); idle_bits(1);
    expect_frame("t4", 8'h5A, 0, 0);

    // reset during data bit 4 of 0xFF
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    wait_cyc(200); reset = 1'b1; wait_cyc(1); reset = 1'b0;
    chk("t5_rst_data", 32'(data_out), 0);
    chk("t5_rst_perr", 32'(parity_err), 0);
    chk("t5_rst_ferr", 32'(frame_err), 0);
    wait_cyc(BITC - 201);
    idle_bits(5);
    chk("t5_rst_cnt", q.size(), 0);

    // two_stop toggled mid-frame must not stretch the frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i), 1'b0);
    two_stop = 1'b1;
    for (int i = 4; i < 8; i++) send_bit(1'(8'hC3 >> i), 1'b0);
    send_bit(1'b1, 1'b0);
    two_stop = 1'b0;
    send_frame(8'h3C, 0, 0, 1, 1, 0, -1); idle_bits(1);
    expect_frame("t5a", 8'hC3, 0, 0);
    expect_frame("t5b", 8'h3C, 0, 0);

    // line held low for two frame times
    rx = 1'b0; wait_cyc(20 * BITC);
    idle_bits(12);
`ifdef UART_RX_BREAK_DET_EN
    chk("t6_brk", brk_cnt, 1);
    chk("t6_novld", q.size(), 0);
    chk("t6_hold", 32'(data_out), 32'h3C);
`else
    expect_frame("t6", 8'h00, 0, 1);
    q.delete();
`endif
    send_frame(8'h11, 0, 0, 1, 1, 0, -1); idle_bits(1);
    expect_frame("t6b", 8'h11, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
